// File: rtl/usb_packet_buffer.sv
// Single-packet circular FIFO shared by the AHB slave, USB RX decoder and USB TX encoder.
// Two push sources and two pop sinks share one store; occupancy is derived from wrap-bit pointers.
module usb_packet_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              flush,
  input  logic              store_tx_data,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              store_rx_data,
  input  logic [DATA_W-1:0] rx_packet_data,
  input  logic              get_rx_data,
  output logic [DATA_W-1:0] rx_data,
  input  logic              get_tx_data,
  output logic [DATA_W-1:0] tx_packet_data,
  output logic [ADDR_W:0]   buffer_occupancy,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow,
  output logic              collision
);

  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] FULL_OCC = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wptr, rptr;
  logic [DATA_W-1:0] push_data, head;
  logic              push_req, pop_req, push_ok, pop_ok, wipe;

  assign buffer_occupancy = wptr - rptr;
  assign full  = (buffer_occupancy == FULL_OCC);
  assign empty = (wptr == rptr);

  assign wipe      = clear | flush;
  assign push_req  = store_tx_data | store_rx_data;
  assign pop_req   = get_rx_data | get_tx_data;
  // AHB data wins a push collision; the RX word is dropped.
  assign push_data = store_tx_data ? tx_data : rx_packet_data;
  // A pop on empty never falls through, so a same-cycle push only needs a slot freed by a real pop.
  assign pop_ok    = pop_req & ~empty;
  assign push_ok   = push_req & (~full | pop_ok);
  assign head      = mem[rptr[ADDR_W-1:0]];

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid,
  // which keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !wipe) mem[wptr[ADDR_W-1:0]] <= push_data;
  end

  // NOTE: non-blocking assignments throughout, so the head read and the full-buffer
  // push/pop on the same slot both see pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr           <= '0;
      rptr           <= '0;
      rx_data        <= '0;
      tx_packet_data <= '0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
      collision      <= 1'b0;
    end else if (wipe) begin
      wptr           <= '0;
      rptr           <= '0;
      rx_data        <= '0;
      tx_packet_data <= '0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
      collision      <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop_ok) begin
        rptr <= rptr + PTR_ONE;
        if (get_rx_data) rx_data        <= head;
        if (get_tx_data) tx_packet_data <= head;
      end
      if (push_req && !push_ok) overflow  <= 1'b1;
      if (pop_req && empty)     underflow <= 1'b1;
      if ((store_tx_data && store_rx_data) || (get_rx_data && get_tx_data)) collision <= 1'b1;
    end
  end

endmodule

// File: tb/tb_usb_packet_buffer.sv
// Directed scoreboard bench for usb_packet_buffer: default 8x64 instance plus a 16x8 instance.
module tb_usb_packet_buffer;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: DATA_W = 8, DEPTH = 64
  logic       a_clear = 0, a_flush = 0, a_stx = 0, a_srx = 0, a_grx = 0, a_gtx = 0;
  logic [7:0] a_tx = '0, a_rxp = '0, a_rx, a_txp;
  logic [6:0] a_occ;
  logic       a_full, a_empty, a_ovf, a_udf, a_col;

  // Instance B: DATA_W = 16, DEPTH = 8
  logic        b_clear = 0, b_flush = 0, b_stx = 0, b_srx = 0, b_grx = 0, b_gtx = 0;
  logic [15:0] b_tx = '0, b_rxp = '0, b_rx, b_txp;
  logic [3:0]  b_occ;
  logic        b_full, b_empty, b_ovf, b_udf, b_col;

  usb_packet_buffer dut_a (
    .clk(clk), .n_rst(n_rst), .clear(a_clear), .flush(a_flush),
    .store_tx_data(a_stx), .tx_data(a_tx), .store_rx_data(a_srx), .rx_packet_data(a_rxp),
    .get_rx_data(a_grx), .rx_data(a_rx), .get_tx_data(a_gtx), .tx_packet_data(a_txp),
    .buffer_occupancy(a_occ), .full(a_full), .empty(a_empty),
    .overflow(a_ovf), .underflow(a_udf), .collision(a_col)
  );

  usb_packet_buffer #(.DATA_W(16), .DEPTH(8)) dut_b (
    .clk(clk), .n_rst(n_rst), .clear(b_clear), .flush(b_flush),
    .store_tx_data(b_stx), .tx_data(b_tx), .store_rx_data(b_srx), .rx_packet_data(b_rxp),
    .get_rx_data(b_grx), .rx_data(b_rx), .get_tx_data(b_gtx), .tx_packet_data(b_txp),
    .buffer_occupancy(b_occ), .full(b_full), .empty(b_empty),
    .overflow(b_ovf), .underflow(b_udf), .collision(b_col)
  );

  logic [15:0] sb_a [$];
  logic [15:0] sb_b [$];
  logic [7:0]  last_rx_a = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of strobes on A; inputs change #1 after the edge, outputs are sampled there too.
  task automatic a_cycle(input logic stx, input logic [7:0] dtx, input logic srx, input logic [7:0] drx,
                         input logic grx, input logic gtx, input logic clr, input logic fl);
    a_stx = stx; a_tx = dtx; a_srx = srx; a_rxp = drx;
    a_grx = grx; a_gtx = gtx; a_clear = clr; a_flush = fl;
    @(posedge clk); #1;
    a_stx = 0; a_srx = 0; a_grx = 0; a_gtx = 0; a_clear = 0; a_flush = 0;
  endtask

  task automatic b_cycle(input logic stx, input logic [15:0] dtx, input logic grx, input logic gtx,
                         input logic fl);
    b_stx = stx; b_tx = dtx; b_grx = grx; b_gtx = gtx; b_flush = fl;
    @(posedge clk); #1;
    b_stx = 0; b_grx = 0; b_gtx = 0; b_flush = 0;
  endtask

  task automatic a_push(input logic [7:0] d);
    a_cycle(1, d, 0, 8'h00, 0, 0, 0, 0);
    sb_a.push_back({8'h00, d});
  endtask

  task automatic a_pop_tx(input string tag);
    logic [15:0] e;
    a_cycle(0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
    e = sb_a.pop_front();
    check(tag, 32'(a_txp), 32'(e));
  endtask

  task automatic a_pop_rx(input string tag);
    logic [15:0] e;
    a_cycle(0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
    e = sb_a.pop_front();
    last_rx_a = e[7:0];
    check(tag, 32'(a_rx), 32'(e));
  endtask

  initial begin
    logic [15:0] e;
    int          occ_before;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_occ", 32'(a_occ), 0);
    check("rst_empty", 32'(a_empty), 1);
    check("rst_full", 32'(a_full), 0);
    check("rst_flags", 32'({a_ovf, a_udf, a_col}), 0);
    check("rst_data", 32'({a_rx, a_txp}), 0);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;

    // Basic AHB push then TX pop
    a_push(8'hA1); check("occ_1", 32'(a_occ), 1); check("not_empty", 32'(a_empty), 0);
    a_push(8'hB2);
    a_push(8'hC3); check("occ_3", 32'(a_occ), 3);
    a_pop_tx("tx_A1"); check("occ_2", 32'(a_occ), 2);
    a_pop_tx("tx_B2");
    a_pop_tx("tx_C3"); check("occ_0", 32'(a_occ), 0); check("empty_again", 32'(a_empty), 1);

    // Fill to DEPTH, overflow, then push+pop while full
    for (int i = 0; i < 64; i++) a_push(8'(i * 3 + 1));
    check("full_set", 32'(a_full), 1);
    check("full_occ", 32'(a_occ), 64);
    check("no_ovf_yet", 32'(a_ovf), 0);
    a_cycle(1, 8'hEE, 0, 8'h00, 0, 0, 0, 0);
    check("ovf_set", 32'(a_ovf), 1);
    check("ovf_occ", 32'(a_occ), 64);
    a_cycle(1, 8'h5A, 0, 8'h00, 1, 0, 0, 0);
    e = sb_a.pop_front();
    sb_a.push_back(16'h005A);
    check("full_pushpop_rx", 32'(a_rx), 32'(e));
    check("full_pushpop_occ", 32'(a_occ), 64);
    check("full_pushpop_full", 32'(a_full), 1);
    for (int i = 0; i < 64; i++) a_pop_rx("drain_rx");
    check("drained_empty", 32'(a_empty), 1);
    check("drain_last_5A", 32'(a_rx), 32'h5A);

    // Underflow, output hold, push+pop on empty
    check("no_udf_yet", 32'(a_udf), 0);
    a_cycle(0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
    check("udf_set", 32'(a_udf), 1);
    check("udf_rx_hold", 32'(a_rx), 32'(last_rx_a));
    a_cycle(0, 8'h00, 0, 8'h00, 0, 0, 1, 0);
    check("clear_udf", 32'(a_udf), 0);
    check("clear_ovf", 32'(a_ovf), 0);
    check("clear_rx", 32'(a_rx), 0);
    a_cycle(1, 8'h77, 0, 8'h00, 1, 0, 0, 0);
    sb_a.push_back(16'h0077);
    check("pp_empty_udf", 32'(a_udf), 1);
    check("pp_empty_occ", 32'(a_occ), 1);
    check("pp_empty_nofall", 32'(a_rx), 0);
    a_pop_rx("pp_empty_word");

    // Index wrap: 48/48 then 40 pushes
    for (int i = 0; i < 48; i++) a_push(8'(i + 8'h80));
    for (int i = 0; i < 48; i++) a_pop_tx("wrap_a");
    for (int i = 0; i < 40; i++) a_push(8'(8'hF0 - i));
    check("wrap_occ_40", 32'(a_occ), 40);
    for (int i = 0; i < 40; i++) a_pop_rx("wrap_b");
    check("wrap_empty", 32'(a_empty), 1);

    // Collisions
    a_cycle(0, 8'h00, 0, 8'h00, 0, 0, 1, 0);
    check("pre_col", 32'(a_col), 0);
    a_cycle(1, 8'h11, 1, 8'h22, 0, 0, 0, 0);
    sb_a.push_back(16'h0011);
    check("push_col", 32'(a_col), 1);
    check("push_col_occ", 32'(a_occ), 1);
    a_cycle(0, 8'h00, 0, 8'h00, 0, 0, 1, 0);
    check("clr_keeps_nothing", 32'(a_occ), 0);
    sb_a.delete();
    a_cycle(1, 8'h11, 1, 8'h22, 0, 0, 0, 0);
    sb_a.push_back(16'h0011);
    a_push(8'h33);
    occ_before = int'(a_occ);
    a_cycle(0, 8'h00, 0, 8'h00, 1, 1, 0, 0);
    e = sb_a.pop_front();
    check("pop_col_rx", 32'(a_rx), 32'(e));
    check("pop_col_tx", 32'(a_txp), 32'(e));
    check("pop_col_occ", 32'(a_occ), 32'(occ_before - 1));
    check("pop_col_flag", 32'(a_col), 1);
    a_pop_tx("after_col_33");

    // Flush with occupancy 10 and flags set
    a_cycle(0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
    check("pre_flush_udf", 32'(a_udf), 1);
    for (int i = 0; i < 10; i++) a_push(8'(i + 8'h40));
    check("pre_flush_occ", 32'(a_occ), 10);
    a_cycle(1, 8'h99, 0, 8'h00, 1, 0, 0, 1);
    sb_a.delete();
    check("flush_occ", 32'(a_occ), 0);
    check("flush_empty", 32'(a_empty), 1);
    check("flush_flags", 32'({a_ovf, a_udf, a_col}), 0);
    check("flush_data", 32'({a_rx, a_txp}), 0);
    a_push(8'h3C);
    a_pop_tx("post_flush_3C");

    // Same flow on the 16-bit x 8 instance
    for (int i = 0; i < 8; i++) begin
      b_cycle(1, 16'(16'hA000 + i * 16'h0111), 0, 0, 0);
      sb_b.push_back(16'(16'hA000 + i * 16'h0111));
    end
    check("b_full", 32'(b_full), 1);
    check("b_occ_8", 32'(b_occ), 8);
    b_cycle(1, 16'hBEEF, 0, 0, 0);
    check("b_ovf", 32'(b_ovf), 1);
    check("b_ovf_occ", 32'(b_occ), 8);
    b_cycle(0, 16'h0000, 1, 1, 0);
    e = sb_b.pop_front();
    check("b_col_rx", 32'(b_rx), 32'(e));
    check("b_col_tx", 32'(b_txp), 32'(e));
    check("b_col", 32'(b_col), 1);
    check("b_occ_7", 32'(b_occ), 7);
    b_cycle(1, 16'h1234, 0, 0, 1);
    sb_b.delete();
    check("b_flush_occ", 32'(b_occ), 0);
    check("b_flush_empty", 32'(b_empty), 1);
    check("b_flush_flags", 32'({b_ovf, b_udf, b_col}), 0);
    check("b_flush_data", 32'({b_rx, b_txp}), 0);

    // Asynchronous reset mid-packet
    a_push(8'h01); a_push(8'h02); a_push(8'h03);
    n_rst = 1'b0;
    #1;
    sb_a.delete();
    check("async_rst_occ", 32'(a_occ), 0);
    check("async_rst_empty", 32'(a_empty), 1);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;
    a_push(8'h42);
    a_pop_tx("post_rst_42");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/usb_packet_buffer.md
# usb_packet_buffer

Parametrised packet FIFO between the AHB-lite slave, the USB RX packet decoder and the USB TX packet encoder. It holds a single data packet in either direction. Two write sources (AHB, RX) and two read sinks (AHB, TX) share one circular store. It reports exact occupancy, full/empty status and sticky error flags, and replaces the fixed 8-bit × 64 buffer with a configurable width/depth block.

## Interface
Parameters:
- DATA_W, 8, data word width in bits
- DEPTH, 64, number of entries; power of two, 4..1024
- ADDR_W, $clog2(DEPTH), derived pointer index width; not overridden

Ports:
- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  asynchronous active-low reset
- clear  input  1  AHB-initiated synchronous buffer clear
- flush  input  1  RX-initiated synchronous buffer clear
- store_tx_data  input  1  AHB push strobe
- tx_data  input  DATA_W  AHB push data
- store_rx_data  input  1  RX push strobe
- rx_packet_data  input  DATA_W  RX push data
- get_rx_data  input  1  AHB pop strobe
- rx_data  output  DATA_W  AHB pop data, registered
- get_tx_data  input  1  TX pop strobe
- tx_packet_data  output  DATA_W  TX pop data, registered
- buffer_occupancy  output  ADDR_W+1  entries currently stored, 0..DEPTH
- full  output  1  occupancy == DEPTH
- empty  output  1  occupancy == 0
- overflow  output  1  sticky: push rejected because buffer full
- underflow  output  1  sticky: pop rejected because buffer empty
- collision  output  1  sticky: two pushes or two pops in one cycle

## Operation
- Storage: DEPTH × DATA_W array, write pointer wptr and read pointer rptr, each ADDR_W+1 bits (MSB = wrap bit). Index = low ADDR_W bits.
- Occupancy = wptr − rptr, modulo 2^(ADDR_W+1). full = (occupancy == DEPTH). empty = (wptr == rptr). All three are combinational from registered pointers.
- Push request = store_tx_data | store_rx_data. If both are asserted: tx_data is used, rx_packet_data is dropped, collision is set.
- Pop request = get_rx_data | get_tx_data. If both are asserted: the single popped word loads both rx_data and tx_packet_data, rptr advances once, collision is set.
- Pop accepted iff !empty. On accept: the head word goes to the requesting output register(s), and rptr increments. Otherwise: no pointer change, underflow is set, and outputs hold.
- Push accepted iff !full, or a pop is accepted in the same cycle. On accept: the word is written at wptr, and wptr increments. Otherwise: the data is discarded and overflow is set.
- Simultaneous accepted push and pop: occupancy is unchanged. Pop on empty is always rejected, with no fall-through, even when a push occurs in the same cycle. That push is still accepted.
- Pointers wrap naturally at 2^(ADDR_W+1). No explicit wrap logic.
- clear | flush (synchronous, highest priority): wptr, rptr, rx_data, tx_packet_data, overflow, underflow and collision all go to 0. Any same-cycle push or pop is ignored. Array contents need not be zeroed.
- rx_data and tx_packet_data hold their value until the next accepted pop addressed to them.

## Timing
- Reset (n_rst low, asynchronous) sets every output to 0, except empty = 1.
- Push latency: occupancy, full and empty reflect the push on the first edge after the strobe. The word is poppable on that next cycle.
- Pop latency: rx_data/tx_packet_data are valid the cycle after the get strobe edge, and the pointer update is on the same edge.
- Sticky flags are set on the edge that samples the offending request. They are cleared only by clear, flush or reset.
- Strobes are single-cycle per word. Back-to-back strobes every cycle are supported at full throughput.
- Reset asserted mid-packet discards all contents immediately. No partial write completes.

## Test plan
- Reset, then 3 AHB pushes (0xA1, 0xB2, 0xC3), then 3 get_tx_data → tx_packet_data = A1, B2, C3 on successive cycles; occupancy 3→0; empty = 1.
- DEPTH pushes → full = 1 and occupancy = DEPTH. One further push → overflow = 1, occupancy unchanged. Push + get_rx_data together while full → both accepted, occupancy stays DEPTH.
- Pop on empty → underflow = 1, rx_data holds its previous value. Push + pop on empty → underflow = 1, occupancy becomes 1.
- Wrap: 48 push / 48 pop, then 40 push → occupancy = 40 across the index wrap, and data order is preserved.
- store_tx_data = store_rx_data = 1 (0x11 / 0x22) → 0x11 stored, collision = 1. get_rx_data = get_tx_data = 1 → both outputs = 0x11, occupancy decrements by 1.
- flush with occupancy 10 and flags set → next cycle occupancy = 0, empty = 1, all flags and data outputs 0. Repeat with DATA_W = 16 and DEPTH = 8.
